// File: rtl/serial_fir_mc.sv
// Multi-channel serial FIR: one signed MAC shared across NUM_CH channels.
// Each channel has its own circular delay line, and all channels share one coefficient set.
module serial_fir_mc #(
    parameter int WIDTH     = 16,
    parameter int LENGTH    = 100,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int OUT_WIDTH = 2*WIDTH + $clog2(LENGTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [WIDTH-1:0]     FIR_input,
    input  logic [CH_W-1:0]             input_ch,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic                        coef_we,
    input  logic [$clog2(LENGTH)-1:0]   coef_addr,
    input  logic signed [WIDTH-1:0]     coef_data,
    output logic signed [OUT_WIDTH-1:0] FIR_output,
    output logic [CH_W-1:0]             output_ch,
    output logic                        output_valid
);

    localparam int CA_W   = $clog2(LENGTH);
    localparam int DEPTH  = NUM_CH * LENGTH;
    localparam int DA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {CLEAR, IDLE, MAC, DONE} state_t;
    state_t state, state_nx;

    logic signed [WIDTH-1:0] delay_mem [DEPTH];
    logic signed [WIDTH-1:0] coef_mem  [LENGTH];

    logic [DA_W-1:0]             clr_cnt;
    logic [CA_W-1:0]             tap;
    logic [CA_W-1:0]             rd_idx;
    logic [CA_W-1:0]             cur_ptr;
    logic [DA_W-1:0]             cur_base;
    logic [CH_W-1:0]             cur_ch;
    logic [CA_W-1:0]             wr_ptr [NUM_CH];
    logic signed [WIDTH-1:0]     sample_reg;
    logic signed [OUT_WIDTH-1:0] acc;

    logic                    ch_ok, coef_ok, accept, take, coef_wr_en;
    logic                    clr_last, tap_last;
    logic                    dly_we, coef_mem_we;
    logic [DA_W-1:0]         dly_waddr, dly_raddr;
    logic signed [WIDTH-1:0] dly_wdata, coef_wdata;
    logic [CA_W-1:0]         coef_waddr, coef_raddr;
    logic signed [WIDTH-1:0] dly_rd, coef_rd;
    logic                    coef_byp;
    logic signed [WIDTH-1:0] coef_byp_data;
    logic signed [WIDTH-1:0] x_op, h_op;
    logic signed [PROD_W-1:0]    prod;
    logic signed [OUT_WIDTH-1:0] acc_sum;

    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = (input_ch < CH_W'(NUM_CH));
        end
        if (LENGTH == (1 << CA_W)) begin : g_coef_full
            assign coef_ok = 1'b1;
        end else begin : g_coef_part
            assign coef_ok = (coef_addr < CA_W'(LENGTH));
        end
    endgenerate

    assign input_ready = (state == IDLE);
    assign accept      = input_ready && input_valid;
    assign take        = accept && ch_ok;
    assign coef_wr_en  = (state == IDLE) && coef_we && coef_ok;
    assign clr_last    = (clr_cnt == DA_W'(DEPTH - 1));
    assign tap_last    = (tap == CA_W'(LENGTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR:   if (clr_last) state_nx = IDLE;
            IDLE:    if (take) state_nx = MAC;
            MAC:     if (tap_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // The clear sweep and sample writes share the single delay-memory write port.
    always_comb begin
        dly_we      = (state == CLEAR) || take;
        dly_waddr   = DA_W'(input_ch) * DA_W'(LENGTH) + DA_W'(wr_ptr[input_ch]);
        dly_wdata   = FIR_input;
        coef_mem_we = coef_wr_en;
        coef_waddr  = coef_addr;
        coef_wdata  = coef_data;
        if (state == CLEAR) begin
            dly_waddr   = clr_cnt;
            dly_wdata   = '0;
            coef_mem_we = (clr_cnt < DA_W'(LENGTH));
            coef_waddr  = clr_cnt[CA_W-1:0];
            coef_wdata  = '0;
        end
    end

    // Reads run one tap ahead so registered RAM data lines up with the tap counter.
    assign dly_raddr  = cur_base + DA_W'(rd_idx);
    assign coef_raddr = (state == MAC && !tap_last) ? tap + CA_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (dly_we) delay_mem[dly_waddr] <= dly_wdata;
        dly_rd <= delay_mem[dly_raddr];
        if (coef_mem_we) coef_mem[coef_waddr] <= coef_wdata;
        coef_rd       <= coef_mem[coef_raddr];
        coef_byp      <= coef_wr_en && (coef_addr == '0);
        coef_byp_data <= coef_data;
    end

    // Tap 0 is the sample just accepted, and h[0] may be written on that same edge.
    assign x_op    = (tap == '0) ? sample_reg : dly_rd;
    assign h_op    = (tap == '0 && coef_byp) ? coef_byp_data : coef_rd;
    assign prod    = x_op * h_op;
    assign acc_sum = acc + {{(OUT_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt      <= '0;
            tap          <= '0;
            rd_idx       <= '0;
            cur_ptr      <= '0;
            cur_base     <= '0;
            cur_ch       <= '0;
            sample_reg   <= '0;
            acc          <= '0;
            FIR_output   <= '0;
            output_ch    <= '0;
            output_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
        end else begin
            output_valid <= 1'b0;
            unique case (state)
                CLEAR: clr_cnt <= clr_last ? '0 : clr_cnt + DA_W'(1);
                IDLE: if (take) begin
                    cur_ch     <= input_ch;
                    cur_base   <= DA_W'(input_ch) * DA_W'(LENGTH);
                    cur_ptr    <= wr_ptr[input_ch];
                    rd_idx     <= (wr_ptr[input_ch] == '0) ? CA_W'(LENGTH - 1)
                                                           : wr_ptr[input_ch] - CA_W'(1);
                    sample_reg <= FIR_input;
                    acc        <= '0;
                    tap        <= '0;
                end
                MAC: begin
                    acc    <= acc_sum;
                    rd_idx <= (rd_idx == '0) ? CA_W'(LENGTH - 1) : rd_idx - CA_W'(1);
                    if (tap_last) begin
                        tap            <= '0;
                        FIR_output     <= acc_sum;
                        output_ch      <= cur_ch;
                        output_valid   <= 1'b1;
                        wr_ptr[cur_ch] <= (cur_ptr == CA_W'(LENGTH - 1)) ? '0
                                                                         : cur_ptr + CA_W'(1);
                    end else begin
                        tap <= tap + CA_W'(1);
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fir_mc.sv
// Directed, table-driven bench for serial_fir_mc with hand-computed expected outputs.
module tb_serial_fir_mc;

    localparam int WIDTH     = 16;
    localparam int LENGTH    = 100;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int CA_W      = $clog2(LENGTH);
    localparam int OUT_WIDTH = 2*WIDTH + $clog2(LENGTH);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic signed [WIDTH-1:0]     FIR_input = '0;
    logic [CH_W-1:0]             input_ch = '0;
    logic                        input_valid = 1'b0;
    logic                        input_ready;
    logic                        coef_we = 1'b0;
    logic [CA_W-1:0]             coef_addr = '0;
    logic signed [WIDTH-1:0]     coef_data = '0;
    logic signed [OUT_WIDTH-1:0] FIR_output;
    logic [CH_W-1:0]             output_ch;
    logic                        output_valid;

    serial_fir_mc #(.WIDTH(WIDTH), .LENGTH(LENGTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst),
        .FIR_input(FIR_input), .input_ch(input_ch),
        .input_valid(input_valid), .input_ready(input_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .FIR_output(FIR_output), .output_ch(output_ch), .output_valid(output_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     ch;
        longint x;
        longint y;
    } vec_t;
    vec_t vecs[$];

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!input_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Pulses rst for one edge, then measures how long the clear sweep keeps input_ready low.
    task automatic do_reset();
        int n = 0;
        bit seen_valid = 1'b0;
        rst = 1'b1; input_valid = 1'b0; coef_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_output", FIR_output, 0);
        check_output("reset_output_ch", longint'(output_ch), 0);
        while (!input_ready && n < 1000) begin
            @(negedge clk);
            n++;
            if (output_valid) seen_valid = 1'b1;
        end
        check_output("clear_cycles", n, NUM_CH * LENGTH);
        check_output("valid_during_clear", longint'(seen_valid), 0);
    endtask

    task automatic write_coef(input int addr, input longint data);
        coef_we = 1'b1; coef_addr = CA_W'(addr); coef_data = WIDTH'(data);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic apply_stimulus(input int ch, input longint x, input bit same_edge_we,
                                  input longint we_data, input bit mac_poke,
                                  output longint y, output int yc, output int lat,
                                  output int acc_cyc, output bit pulse_ok);
        wait_ready();
        check_output("ready_wait", longint'(input_ready), 1);
        input_ch = CH_W'(ch); FIR_input = WIDTH'(x); input_valid = 1'b1;
        coef_we = same_edge_we; coef_addr = '0; coef_data = WIDTH'(we_data);
        @(negedge clk);
        acc_cyc = cyc;
        input_valid = 1'b0; coef_we = 1'b0; FIR_input = '0;
        lat = -1; y = 0; yc = -1;
        for (int k = 1; k <= LENGTH + 4; k++) begin
            if (mac_poke && k == 40) begin
                coef_we = 1'b1; coef_addr = CA_W'(5); coef_data = '0;
                input_valid = 1'b1; FIR_input = 16'sd5; input_ch = 2'd3;
            end
            if (mac_poke && k == 60) begin
                coef_we = 1'b0; input_valid = 1'b0; FIR_input = '0;
            end
            @(negedge clk);
            if (output_valid) begin
                lat = k; y = FIR_output; yc = int'(output_ch);
                break;
            end
        end
        @(negedge clk);
        pulse_ok = !output_valid && input_ready;
    endtask

    task automatic run_table(input string tag);
        longint y;
        int yc, lat, acc_cyc, prev_cyc;
        bit pulse_ok;
        prev_cyc = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].ch, vecs[i].x, 1'b0, 0, 1'b0, y, yc, lat, acc_cyc, pulse_ok);
            check_output($sformatf("%s[%0d].y", tag, i), y, vecs[i].y);
            check_output($sformatf("%s[%0d].ch", tag, i), yc, vecs[i].ch);
            check_output($sformatf("%s[%0d].latency", tag, i), lat, LENGTH);
            check_output($sformatf("%s[%0d].pulse", tag, i), longint'(pulse_ok), 1);
            if (prev_cyc >= 0)
                check_output($sformatf("%s[%0d].accept_gap", tag, i), acc_cyc - prev_cyc, LENGTH + 2);
            prev_cyc = acc_cyc;
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint y;
        int yc, lat, acc_cyc;
        bit pulse_ok;

        @(negedge clk);
        do_reset();

        // Impulse on ch0 with h[k]=k+1 walks the coefficients out one by one.
        for (int k = 0; k < LENGTH; k++) write_coef(k, k + 1);
        vecs.delete();
        vecs.push_back('{0, 1, 1});
        for (int k = 1; k < LENGTH; k++) vecs.push_back('{0, 0, k + 1});
        vecs.push_back('{0, 0, 0});
        run_table("impulse");

        for (int k = 0; k < LENGTH; k++) write_coef(k, 1);
        vecs.delete();
        for (int n = 0; n < LENGTH; n++) vecs.push_back('{2, -32768, -32768 * longint'(n + 1)});
        run_table("step");

        vecs.delete();
        for (int r = 0; r < 4; r++) begin
            vecs.push_back('{1, (r == 0) ? 1000 : 0, 1000});
            vecs.push_back('{0, 0, 0});
            vecs.push_back('{3, 0, 0});
        end
        run_table("isolation");

        for (int k = 0; k < LENGTH; k++) write_coef(k, -32768);
        vecs.delete();
        for (int n = 0; n < LENGTH - 1; n++) vecs.push_back('{3, -32768, 1073741824 * longint'(n + 1)});
        run_table("extreme");

        apply_stimulus(3, -32768, 1'b0, 0, 1'b1, y, yc, lat, acc_cyc, pulse_ok);
        check_output("extreme_final", y, 64'sd107374182400);
        check_output("extreme_final_latency", lat, LENGTH);
        apply_stimulus(3, -32768, 1'b0, 0, 1'b0, y, yc, lat, acc_cyc, pulse_ok);
        check_output("coef_we_in_mac_ignored", y, 64'sd107374182400);

        // Reset lands mid-MAC, and the in-flight sample must never produce a result.
        wait_ready();
        input_ch = 2'd3; FIR_input = 16'sd99; input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        repeat (50) @(negedge clk);
        check_output("mid_mac_no_valid", longint'(output_valid), 0);
        do_reset();

        apply_stimulus(3, 1234, 1'b0, 0, 1'b0, y, yc, lat, acc_cyc, pulse_ok);
        check_output("post_reset_y", y, 0);
        check_output("post_reset_ch", yc, 3);
        check_output("post_reset_latency", lat, LENGTH);

        write_coef(1, 2);
        write_coef(2, 1);
        write_coef(LENGTH + 10, 77);
        apply_stimulus(3, 7, 1'b1, 3, 1'b0, y, yc, lat, acc_cyc, pulse_ok);
        check_output("same_edge_coef_y", y, 3*7 + 2*1234);
        check_output("same_edge_coef_pulse", longint'(pulse_ok), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
